// File: rtl/gf180mcu_fd_sc_mcu9t5v0__parchk_rx_1.sv
// Serial frame receiver with parity check: SOF-qualified LSB-first data bits,
// then one parity bit. It reports the word and the parity error with a one-cycle VLD pulse.
module gf180mcu_fd_sc_mcu9t5v0__parchk_rx_1 #(
    parameter int W   = 8,
    parameter int ODD = 0
) (
    input  logic         CLK,
    input  logic         RST,
    inout  wire          VDD,
    inout  wire          VSS,
    input  logic         EN,
    input  logic         D,
    input  logic         SOF,
    output logic [W-1:0] Q,
    output logic         VLD,
    output logic         PERR,
    output logic         BUSY
);

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_PAR  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_n;
    logic [CW-1:0]  r_cnt;
    logic [CW-1:0]  w_cnt_n;
    logic [W-1:0]   r_shift;
    logic [W-1:0]   w_shift_n;
    logic           r_par;
    logic           w_par_n;
    logic [W-1:0]   r_q;
    logic [W-1:0]   w_q_n;
    logic           r_vld;
    logic           w_vld_n;
    logic           r_perr;
    logic           w_perr_n;

    // Supply pins carry no logic; the name keeps lint from flagging them.
    wire w_unused_pwr;
    assign w_unused_pwr = VDD ^ VSS;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_shift <= '0;
            r_par   <= 1'b0;
            r_q     <= '0;
            r_vld   <= 1'b0;
            r_perr  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            r_shift <= w_shift_n;
            r_par   <= w_par_n;
            r_q     <= w_q_n;
            r_vld   <= w_vld_n;
            r_perr  <= w_perr_n;
        end
    end

    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_shift_n = r_shift;
        w_par_n   = r_par;
        w_q_n     = r_q;
        w_vld_n   = 1'b0;
        w_perr_n  = r_perr;

        if (EN) begin
            if (SOF) begin
                // SOF always restarts, even mid-frame or on the parity sample.
                w_state_n    = S_DATA;
                w_cnt_n      = CW'(1);
                w_shift_n    = '0;
                w_shift_n[0] = D;
                w_par_n      = D;
            end else begin
                case (r_state)
                    S_DATA: begin
                        for (int i = 0; i < W; i++) begin
                            if (r_cnt == CW'(i)) w_shift_n[i] = D;
                        end
                        w_par_n = r_par ^ D;
                        if (r_cnt == CW'(W - 1)) begin
                            w_state_n = S_PAR;
                            w_cnt_n   = '0;
                        end else begin
                            w_cnt_n = r_cnt + CW'(1);
                        end
                    end
                    S_PAR: begin
                        w_state_n = S_IDLE;
                        w_vld_n   = 1'b1;
                        w_q_n     = r_shift;
                        w_perr_n  = r_par ^ D ^ (ODD != 0);
                    end
                    default: begin
                        w_state_n = S_IDLE;
                    end
                endcase
            end
        end
    end

    assign Q    = r_q;
    assign VLD  = r_vld;
    assign PERR = r_perr;
    assign BUSY = (r_state != S_IDLE);

endmodule

// File: doc/gf180mcu_fd_sc_mcu9t5v0__parchk_rx_1.md
GF180MCU_FD_SC_MCU9T5V0__PARCHK_RX_1 -- requirements
Module: gf180mcu_fd_sc_mcu9t5v0__parchk_rx_1

Interface
REQ-001 Parameter W, default 8: number of data bits per frame, legal range 2..16.
REQ-002 Parameter ODD, default 0: 0 selects even parity, 1 selects odd parity.
REQ-003 CLK  input  1  single clock; all state updates on the rising edge.
REQ-004 RST  input  1  reset, asynchronous and active-high.
REQ-005 VDD  inout  1  power; VSS  inout  1  ground; neither has a functional role in RTL.
REQ-006 EN  input  1  bit strobe; D and SOF are sampled only on rising CLK edges where EN=1.
REQ-007 D  input  1  serial data bit, LSB first, followed by one parity bit.
REQ-008 SOF  input  1  start of frame; qualifies the first data bit when sampled with EN=1.
REQ-009 Q  output  W  last received data word.
REQ-010 VLD  output  1  one-cycle pulse when a complete frame has been received.
REQ-011 PERR  output  1  parity-error flag for the frame reported with VLD.
REQ-012 BUSY  output  1  high while a frame is in progress (state DATA or PAR).

Function
REQ-013 State machine SHALL have 3 states: IDLE, DATA, PAR, held in registers updated on CLK.
REQ-014 IDLE: EN=1 and SOF=1 -> capture D as bit 0, set bit counter to 1, go to DATA; EN=1 and SOF=0 -> D ignored, stay in IDLE.
REQ-015 DATA: each EN=1 sample shifts D into bit position = counter, counter+1; the sample that fills bit W-1 moves the FSM to PAR.
REQ-016 PAR: the next EN=1 sample is the parity bit; the FSM returns to IDLE.
REQ-017 EN=0 in any state holds all state, counter, and the shift register unchanged.
REQ-018 A running parity register SHALL accumulate the XOR of every sampled data bit; it is cleared on frame start.
REQ-019 Error: even mode PERR = (XOR of data bits) XOR parity bit; odd mode PERR = inverse of that value.
REQ-020 On the parity sample: VLD=1 and Q=shift register on the following cycle only; PERR is valid in that same cycle; latency is 1 cycle after the parity-bit edge.
REQ-021 Q and PERR hold their values until the next VLD; VLD is low in all other cycles.
REQ-022 SOF=1 with EN=1 in DATA or PAR aborts the current frame without a VLD pulse and restarts at bit 0 with the current D.
REQ-023 SOF=1 with EN=1 on the parity sample of a frame: the frame is aborted (no VLD) and a new frame starts; this is the same rule as REQ-022, and the abort takes priority.
REQ-024 The counter SHALL be ceil(log2(W+1)) bits wide and never exceed W-1 in DATA.
REQ-025 BUSY=1 exactly when the state is DATA or PAR.

Reset
REQ-026 RST=1 SHALL immediately force, without waiting for CLK: state=IDLE, counter=0, shift register=0, parity register=0, Q=0, VLD=0, PERR=0, BUSY=0.
REQ-027 RST asserted mid-frame discards the partial frame; no VLD is produced for it after release.
REQ-028 After RST is deasserted, the first frame SHALL require a fresh SOF.

Verification
REQ-029 W=8, ODD=0, EN=1 every cycle, SOF with bits 1,0,1,0,0,0,0,0 (0x05), parity 0 -> one cycle after the parity edge: VLD=1, Q=0x05, PERR=0.
REQ-030 Same frame with parity 1 -> VLD=1, Q=0x05, PERR=1; with ODD=1, parity 1 -> PERR=0.
REQ-031 Frame 0xA5 sent with EN toggling 1,0,1,0 -> Q=0xA5, VLD exactly once, BUSY high from the SOF edge through the parity edge.
REQ-032 SOF reasserted after 4 data bits, then a full frame of 0x3C with correct parity -> a single VLD, Q=0x3C, PERR=0.
REQ-033 RST pulsed asynchronously after 5 data bits -> all outputs 0 at once, no VLD; the next complete frame 0xFF with parity 0 in even mode -> Q=0xFF, PERR=0.
REQ-034 Bits sent with SOF=0 while IDLE -> BUSY=0 and no VLD.
